// File: rtl/mips_pkg.sv
// Shared MIPS constants: default address width, the $ra register index and
// the opcode/funct encodings the decode logic uses to raise push and pop.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [4:0] RA_REG = 5'd31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  // True when a register specifier names the link register.
  function automatic logic is_ra(input logic [4:0] reg_idx);
    return reg_idx == RA_REG;
  endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x ADDR_W register array with one write port
// and an asynchronous read port, cleared on reset.
module ras_mem #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack predicting JR $ra targets from PC+4 captured at JAL decode.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module ret_addr_stack
  import mips_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] pred_addr,
  output logic              pred_valid,
  output logic              overflow,
  output logic              underflow
`ifdef RAS_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       ovf_count,
  output logic [15:0]       unf_count
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  tos, tos_next;
  logic [PTR_W:0]    count, count_next;
  logic              ovf_next, unf_next;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;

  ras_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(push_addr),
    .raddr(tos),
    .rdata(pred_addr)
  );

  assign pred_valid = (count != '0);

  // Flush beats stall beats push/pop; push+pop on a non-empty stack replaces the top.
  always_comb begin
    tos_next   = tos;
    count_next = count;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = tos + 1'b1;
    if (flush) begin
      count_next = '0;
    end else if (!stall) begin
      if (push && pop && (count != '0)) begin
        wr_en   = 1'b1;
        wr_addr = tos;
      end else if (push) begin
        wr_en    = 1'b1;
        tos_next = tos + 1'b1;
        if (count == FULL_COUNT) begin
          ovf_next = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end else if (pop) begin
        if (count != '0) begin
          tos_next   = tos - 1'b1;
          count_next = count - 1'b1;
        end else begin
          unf_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= tos_next;
      count     <= count_next;
      overflow  <= ovf_next;
      underflow <= unf_next;
    end
  end

`ifdef RAS_STATS_EN
  // Counters step on the same edge that raises the pulse; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else if (stats_clr) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      if (ovf_next && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 1'b1;
      if (unf_next && (unf_count != 16'hFFFF)) unf_count <= unf_count + 1'b1;
    end
  end
`endif

endmodule
